// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: framed commands (A5, code, arg_h, arg_l, xor checksum)
// plus single-character '+'/'-' shortcuts, with inter-byte timeout and error counting.
module uart_cmd_parser #(
    parameter int unsigned P_TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_arg,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ARG_H = 3'd2,
        S_ARG_L = 3'd3,
        S_CHK   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(P_TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [15:0] arg_q, arg_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic [15:0] cmd_arg_q, cmd_arg_d;
    logic [15:0] gap_q, gap_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        accept;
    logic        in_frame;

    assign accept   = byte_valid & ready_q;
    assign in_frame = (state_q == S_CMD) || (state_q == S_ARG_H) ||
                      (state_q == S_ARG_L) || (state_q == S_CHK);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        arg_d       = arg_q;
        chk_d       = chk_q;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        gap_d       = '0;
        err_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (byte_data)
                        8'hA5: state_d = S_CMD;
                        8'h2B: begin
                            cmd_code_d = 8'h01;
                            cmd_arg_d  = 16'h0001;
                            state_d    = S_OUT;
                        end
                        8'h2D: begin
                            cmd_code_d = 8'h02;
                            cmd_arg_d  = 16'h0001;
                            state_d    = S_OUT;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_CMD: begin
                if (accept) begin
                    code_d  = byte_data;
                    chk_d   = byte_data;
                    state_d = S_ARG_H;
                end
            end
            S_ARG_H: begin
                if (accept) begin
                    arg_d[15:8] = byte_data;
                    chk_d       = chk_q ^ byte_data;
                    state_d     = S_ARG_L;
                end
            end
            S_ARG_L: begin
                if (accept) begin
                    arg_d[7:0] = byte_data;
                    chk_d      = chk_q ^ byte_data;
                    state_d    = S_CHK;
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (byte_data == chk_q) begin
                        cmd_code_d = code_q;
                        cmd_arg_d  = arg_q;
                        state_d    = S_OUT;
                    end else begin
                        err_pulse_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (cmd_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An accepted byte wins over a timeout firing in the same cycle.
        if (in_frame && !accept) begin
            if (gap_q == GAP_LAST) begin
                state_d     = S_IDLE;
                err_pulse_d = 1'b1;
            end else begin
                gap_d = gap_q + 16'd1;
            end
        end

        err_cnt_d = err_cnt_q;
        if (err_pulse_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

        ready_d = (state_d != S_OUT);
        valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            arg_q       <= '0;
            chk_q       <= '0;
            cmd_code_q  <= '0;
            cmd_arg_q   <= '0;
            gap_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            arg_q       <= arg_d;
            chk_q       <= chk_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            gap_q       <= gap_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign byte_ready = ready_q;
    assign cmd_valid  = valid_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_arg    = cmd_arg_q;
    assign err_pulse  = err_pulse_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a frame-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_uart_cmd_parser;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_arg;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int n_pass = 0;
    int n_checks = 0;
    bit cmp_en = 1'b0;

    uart_cmd_parser #(.P_TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .cmd_code   (cmd_code),
        .cmd_arg    (cmd_arg),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: collects frame bytes into an array, judges the frame when complete.
    bit         m_pending = 1'b0;
    bit         m_open = 1'b0;
    int         m_len = 0;
    int         m_gap = 0;
    logic [7:0] m_frame [4];
    logic [7:0] e_code = 8'h00;
    logic [15:0] e_arg = 16'h0000;
    logic       e_err = 1'b0;
    int         e_cnt = 0;

    task automatic emit(input logic [7:0] c, input logic [15:0] a);
        e_code    = c;
        e_arg     = a;
        m_pending = 1'b1;
    endtask

    task automatic model_step();
        bit err;
        err = 1'b0;
        if (!rst_n) begin
            m_pending = 1'b0;
            m_open    = 1'b0;
            m_len     = 0;
            m_gap     = 0;
            e_code    = 8'h00;
            e_arg     = 16'h0000;
            e_err     = 1'b0;
            e_cnt     = 0;
            return;
        end
        if (m_pending) begin
            if (cmd_ready) m_pending = 1'b0;
        end else if (byte_valid) begin
            m_gap = 0;
            if (!m_open) begin
                if (byte_data == 8'hA5) begin
                    m_open = 1'b1;
                    m_len  = 0;
                end else if (byte_data == 8'h2B) emit(8'h01, 16'h0001);
                else if (byte_data == 8'h2D) emit(8'h02, 16'h0001);
            end else begin
                m_frame[m_len] = byte_data;
                m_len++;
                if (m_len == 4) begin
                    m_open = 1'b0;
                    if (m_frame[3] == (m_frame[0] ^ m_frame[1] ^ m_frame[2]))
                        emit(m_frame[0], {m_frame[1], m_frame[2]});
                    else
                        err = 1'b1;
                end
            end
        end else if (m_open) begin
            if (m_gap == TO - 1) begin
                m_open = 1'b0;
                err    = 1'b1;
            end else begin
                m_gap++;
            end
        end
        e_err = err;
        if (err && e_cnt < 255) e_cnt++;
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("byte_ready", 32'(byte_ready), 32'(!m_pending));
            check("cmd_valid",  32'(cmd_valid),  32'(m_pending));
            check("cmd_code",   32'(cmd_code),   32'(e_code));
            check("cmd_arg",    32'(cmd_arg),    32'(e_arg));
            check("err_pulse",  32'(err_pulse),  32'(e_err));
            check("err_cnt",    32'(err_cnt),    32'(e_cnt));
        end
    end

    task automatic send(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] bi;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_ready", 32'(byte_ready), 32'd1);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_code", 32'(cmd_code), 32'h00);
        check("rst_errcnt", 32'(err_cnt), 32'h00);
        rst_n = 1'b1;
        tick();

        // Good frame, consumer always ready
        send(8'hA5); send(8'h10); send(8'h12); send(8'h34); send(8'h36);
        check("good_valid", 32'(cmd_valid), 32'd1);
        check("good_code", 32'(cmd_code), 32'h10);
        check("good_arg", 32'(cmd_arg), 32'h1234);
        tick();
        check("good_release", 32'(cmd_valid), 32'd0);
        check("good_errcnt", 32'(err_cnt), 32'd0);

        // Bad checksum, then a good frame
        send(8'hA5); send(8'h10); send(8'h12); send(8'h34); send(8'h00);
        check("bad_pulse", 32'(err_pulse), 32'd1);
        check("bad_errcnt", 32'(err_cnt), 32'd1);
        check("bad_novalid", 32'(cmd_valid), 32'd0);
        tick();
        check("bad_pulse_once", 32'(err_pulse), 32'd0);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h05); send(8'h04);
        check("next_code", 32'(cmd_code), 32'h01);
        check("next_arg", 32'(cmd_arg), 32'h0005);
        tick();

        // '+' held by backpressure while another byte waits
        cmd_ready = 1'b0;
        send(8'h2B);
        check("plus_valid", 32'(cmd_valid), 32'd1);
        check("plus_ready", 32'(byte_ready), 32'd0);
        byte_data  = 8'h2D;
        byte_valid = 1'b1;
        repeat (10) tick();
        check("plus_hold_code", 32'(cmd_code), 32'h01);
        check("plus_hold_arg", 32'(cmd_arg), 32'h0001);
        check("plus_hold_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        tick();
        check("plus_released", 32'(cmd_valid), 32'd0);
        tick();
        byte_valid = 1'b0;
        check("minus_code", 32'(cmd_code), 32'h02);
        check("minus_valid", 32'(cmd_valid), 32'd1);
        tick();

        // Byte arrives on the very cycle the timeout would fire
        send(8'hA5); send(8'h10);
        repeat (TO - 1) tick();
        send(8'h12); send(8'h34); send(8'h36);
        check("edge_valid", 32'(cmd_valid), 32'd1);
        check("edge_errcnt", 32'(err_cnt), 32'd1);
        tick();

        // Timeout after A5,10 then idle input
        send(8'hA5); send(8'h10);
        repeat (TO - 1) tick();
        check("to_not_yet", 32'(err_pulse), 32'd0);
        tick();
        check("to_pulse", 32'(err_pulse), 32'd1);
        check("to_errcnt", 32'(err_cnt), 32'd2);
        send(8'h2D);
        check("to_minus_code", 32'(cmd_code), 32'h02);
        check("to_minus_arg", 32'(cmd_arg), 32'h0001);
        tick();

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            bi = 8'(i);
            send(8'hA5); send(bi); send(8'h00); send(8'h00); send(bi ^ 8'h5A);
        end
        check("sat_errcnt", 32'(err_cnt), 32'hFF);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        check("sat_nowrap", 32'(err_cnt), 32'hFF);
        tick();

        // Reset in the middle of a frame
        send(8'hA5); send(8'h10); send(8'h12);
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready", 32'(byte_ready), 32'd1);
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_code", 32'(cmd_code), 32'h00);
        check("mid_rst_arg", 32'(cmd_arg), 32'h0000);
        check("mid_rst_errcnt", 32'(err_cnt), 32'h00);
        rst_n = 1'b1;
        tick();
        send(8'hA5); send(8'h7F); send(8'h80); send(8'h01); send(8'hFE);
        check("post_rst_code", 32'(cmd_code), 32'h7F);
        check("post_rst_arg", 32'(cmd_arg), 32'h8001);
        check("post_rst_errcnt", 32'(err_cnt), 32'h00);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: P_TIMEOUT_CYC, default 20000, inter-byte gap in clk cycles before an open frame is aborted; legal range 2..65535.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 byte_data  input  8  received byte from the UART receiver.
REQ-005 byte_valid  input  1  byte_data is valid; held until accepted.
REQ-006 byte_ready  output  1  parser can accept a byte this cycle.
REQ-007 cmd_code  output  8  decoded command code.
REQ-008 cmd_arg  output  16  decoded command argument.
REQ-009 cmd_valid  output  1  cmd_code and cmd_arg are valid.
REQ-010 cmd_ready  input  1  consumer accepts the command.
REQ-011 err_pulse  output  1  one-cycle pulse on a checksum failure or a timeout.
REQ-012 err_cnt  output  8  saturating count of errors.

Function
REQ-013 A byte SHALL be accepted on a rising edge where byte_valid and byte_ready are both 1.
REQ-014 byte_ready SHALL be 1 in states IDLE, CMD, ARG_H, ARG_L and CHK, and 0 in state OUT; it is decoded from state only and has no combinational path from byte_valid.
REQ-015 IDLE: an accepted 0xA5 SHALL move the block to CMD.
REQ-016 IDLE: an accepted 0x2B ('+') SHALL load cmd_code=0x01 and cmd_arg=0x0001, then move to OUT.
REQ-017 IDLE: an accepted 0x2D ('-') SHALL load cmd_code=0x02 and cmd_arg=0x0001, then move to OUT.
REQ-018 IDLE: any other accepted byte SHALL be discarded silently, with no error, and the block stays in IDLE.
REQ-019 CMD: the accepted byte SHALL be stored as the code, and the running checksum is set to that byte; next state ARG_H.
REQ-020 ARG_H: the accepted byte SHALL be stored as arg[15:8] and XORed into the checksum; next state ARG_L.
REQ-021 ARG_L: the accepted byte SHALL be stored as arg[7:0] and XORed into the checksum; next state CHK.
REQ-022 CHK: if the accepted byte equals code ^ arg_h ^ arg_l, the block SHALL move to OUT.
REQ-023 CHK: on a checksum mismatch the block SHALL pulse err_pulse for one cycle, increment err_cnt and return to IDLE; cmd_code and cmd_arg are not updated.
REQ-024 cmd_code and cmd_arg SHALL update only on entry to OUT and hold their values otherwise.
REQ-025 OUT: cmd_valid SHALL be 1 with outputs stable; on an edge where cmd_valid and cmd_ready are both 1, the block returns to IDLE and cmd_valid is 0 the next cycle.
REQ-026 Latency: cmd_valid SHALL assert on the cycle after the edge that accepts the final byte (checksum byte or single-character byte).
REQ-027 Timeout: a 16-bit gap counter SHALL run in CMD, ARG_H, ARG_L and CHK, cleared on every accepted byte and on entry to these states.
REQ-028 When the gap counter reaches P_TIMEOUT_CYC-1 with no byte accepted, the block SHALL go to IDLE, pulse err_pulse and increment err_cnt.
REQ-029 If a byte is accepted in the same cycle the timeout fires, the byte SHALL take priority and the timeout is ignored.
REQ-030 err_cnt SHALL saturate at 0xFF and never wrap.
REQ-031 The gap counter SHALL be held at 0 in IDLE and OUT; OUT has no timeout.
REQ-032 An illegal state encoding SHALL return the block to IDLE on the next edge.

Reset
REQ-033 While rst_n=0, the block SHALL be held in IDLE with byte_ready=1, cmd_valid=0, cmd_code=0x00, cmd_arg=0x0000, err_pulse=0, err_cnt=0x00, and the gap counter and checksum at 0.
REQ-034 Reset asserted mid-frame or in OUT SHALL discard the partial frame or pending command, with no error counted.

Verification
REQ-035 Bytes A5,10,12,34,36 with cmd_ready=1 -> one cycle of cmd_valid with cmd_code=0x10 and cmd_arg=0x1234; err_cnt stays 0.
REQ-036 Bytes A5,10,12,34,00 -> no cmd_valid; one err_pulse; err_cnt=1; the next frame A5,01,00,05,04 decodes correctly.
REQ-037 Byte '+' with cmd_ready=0 for 10 cycles -> cmd_valid=1 with code 0x01 and arg 0x0001 held stable and byte_ready=0 throughout; release occurs on the edge where cmd_ready=1.
REQ-038 With P_TIMEOUT_CYC=8, bytes A5,10 followed by idle input -> err_pulse once the gap counter reaches 7; state returns to IDLE; a following '-' yields code 0x02.
REQ-039 300 bad-checksum frames -> err_cnt=0xFF and it does not wrap.
REQ-040 rst_n pulsed low after A5,10,12 -> all outputs at reset values; a following full frame decodes correctly.
